// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store unit: FSM states, RV32
// width codes and the store lane encoders.
package lsu_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_DONE = 2'd3
  } lsu_state_e;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam int unsigned LSU_MAX_WAIT_DEF = 255;

  function automatic logic [3:0] st_strb(input logic [2:0] f3, input logic [1:0] a);
    case (f3)
      F3_B:    st_strb = 4'b0001 << a;
      F3_H:    st_strb = a[1] ? 4'b1100 : 4'b0011;
      default: st_strb = 4'b1111;
    endcase
  endfunction

  // Replicate narrow store data into every lane so the strobe alone picks the bytes.
  function automatic logic [31:0] st_data(input logic [2:0] f3, input logic [31:0] d);
    case (f3)
      F3_B:    st_data = {4{d[7:0]}};
      F3_H:    st_data = {2{d[15:0]}};
      default: st_data = d;
    endcase
  endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Picks the addressed byte/half out of an aligned read word and extends it.
module lsu_load_align
  import lsu_pkg::*;
(
  input  logic [31:0] rdata_i,
  input  logic [1:0]  addr_i,
  input  logic [2:0]  funct3_i,
  output logic [31:0] data_o
);

  logic [7:0]  byte_v;
  logic [15:0] half_v;

  always_comb begin
    case (addr_i)
      2'd0:    byte_v = rdata_i[7:0];
      2'd1:    byte_v = rdata_i[15:8];
      2'd2:    byte_v = rdata_i[23:16];
      default: byte_v = rdata_i[31:24];
    endcase
    half_v = addr_i[1] ? rdata_i[31:16] : rdata_i[15:0];

    case (funct3_i)
      F3_B:    data_o = {{24{byte_v[7]}}, byte_v};
      F3_H:    data_o = {{16{half_v[15]}}, half_v};
      F3_W:    data_o = rdata_i;
      F3_BU:   data_o = {24'd0, byte_v};
      F3_HU:   data_o = {16'd0, half_v};
      default: data_o = 32'd0;
    endcase
  end

endmodule

// File: rtl/lsu_ctrl.sv
// Single-outstanding load/store controller: accepts one op from execute,
// drives one aligned bus request, waits under a timeout, returns one wb beat.
module lsu_ctrl
  import lsu_pkg::*;
#(
  parameter int unsigned MAX_WAIT = LSU_MAX_WAIT_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ex_valid,
  output logic        ex_ready,
  input  logic        ex_is_load,
  input  logic        ex_is_store,
  input  logic [2:0]  ex_funct3,
  input  logic [31:0] ex_addr,
  input  logic [31:0] ex_wdata,
  input  logic [4:0]  ex_rd,
  output logic        mem_req_valid,
  input  logic        mem_req_ready,
  output logic        mem_wen,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_wstrb,
  output logic [31:0] mem_wdata,
  input  logic        mem_rsp_valid,
  input  logic [31:0] mem_rsp_rdata,
  output logic        wb_valid,
  input  logic        wb_ready,
  output logic [31:0] wb_rdata,
  output logic [4:0]  wb_rd,
  output logic        wb_err
);

  localparam logic [7:0] CNT_LAST = 8'(MAX_WAIT - 1);

  lsu_state_e  state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [1:0]  alo_q, alo_d;
  logic [2:0]  f3_q, f3_d;
  logic        load_q, load_d;
  logic        wen_q, wen_d;
  logic [31:0] maddr_q, maddr_d;
  logic [3:0]  strb_q, strb_d;
  logic [31:0] mwdata_q, mwdata_d;
  logic [31:0] rdata_q, rdata_d;
  logic [4:0]  rd_q, rd_d;
  logic        err_q, err_d;

  logic [31:0] ld_ext;
  logic        misalign, illegal, timeout;

  lsu_load_align u_align (
    .rdata_i  (mem_rsp_rdata),
    .addr_i   (alo_q),
    .funct3_i (f3_q),
    .data_o   (ld_ext)
  );

  always_comb begin
    misalign = (((ex_funct3 == F3_H) || (ex_funct3 == F3_HU)) && ex_addr[0]) ||
               ((ex_funct3 == F3_W) && (ex_addr[1:0] != 2'b00));
    if (ex_is_store)
      illegal = !((ex_funct3 == F3_B) || (ex_funct3 == F3_H) || (ex_funct3 == F3_W));
    else
      illegal = !((ex_funct3 == F3_B) || (ex_funct3 == F3_H) || (ex_funct3 == F3_W) ||
                  (ex_funct3 == F3_BU) || (ex_funct3 == F3_HU));
    timeout = (cnt_q == CNT_LAST);
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    alo_d    = alo_q;
    f3_d     = f3_q;
    load_d   = load_q;
    wen_d    = wen_q;
    maddr_d  = maddr_q;
    strb_d   = strb_q;
    mwdata_d = mwdata_q;
    rdata_d  = rdata_q;
    rd_d     = rd_q;
    err_d    = err_q;

    case (state_q)
      S_IDLE: begin
        if (ex_valid) begin
          alo_d   = ex_addr[1:0];
          f3_d    = ex_funct3;
          load_d  = ex_is_load;
          rd_d    = ex_rd;
          rdata_d = 32'd0;
          err_d   = 1'b0;
          if (!(ex_is_load || ex_is_store)) begin
            state_d = S_DONE;
          end else if (misalign || illegal) begin
            state_d = S_DONE;
            err_d   = 1'b1;
          end else begin
            state_d  = S_REQ;
            cnt_d    = 8'd0;
            wen_d    = ex_is_store;
            maddr_d  = {ex_addr[31:2], 2'b00};
            strb_d   = ex_is_store ? st_strb(ex_funct3, ex_addr[1:0]) : 4'b0000;
            mwdata_d = ex_is_store ? st_data(ex_funct3, ex_wdata) : 32'd0;
          end
        end
      end
      // A handshake in the last allowed cycle wins over the timeout.
      S_REQ: begin
        cnt_d = cnt_q + 8'd1;
        if (mem_req_ready) begin
          state_d = S_WAIT;
        end else if (timeout) begin
          state_d = S_DONE;
          err_d   = 1'b1;
        end
      end
      S_WAIT: begin
        cnt_d = cnt_q + 8'd1;
        if (mem_rsp_valid) begin
          state_d = S_DONE;
          rdata_d = load_q ? ld_ext : 32'd0;
        end else if (timeout) begin
          state_d = S_DONE;
          err_d   = 1'b1;
        end
      end
      S_DONE: begin
        if (wb_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= 8'd0;
      alo_q    <= 2'd0;
      f3_q     <= 3'd0;
      load_q   <= 1'b0;
      wen_q    <= 1'b0;
      maddr_q  <= 32'd0;
      strb_q   <= 4'd0;
      mwdata_q <= 32'd0;
      rdata_q  <= 32'd0;
      rd_q     <= 5'd0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      alo_q    <= alo_d;
      f3_q     <= f3_d;
      load_q   <= load_d;
      wen_q    <= wen_d;
      maddr_q  <= maddr_d;
      strb_q   <= strb_d;
      mwdata_q <= mwdata_d;
      rdata_q  <= rdata_d;
      rd_q     <= rd_d;
      err_q    <= err_d;
    end
  end

  assign ex_ready      = (state_q == S_IDLE);
  assign mem_req_valid = (state_q == S_REQ);
  assign wb_valid      = (state_q == S_DONE);
  assign mem_wen       = wen_q;
  assign mem_addr      = maddr_q;
  assign mem_wstrb     = strb_q;
  assign mem_wdata     = mwdata_q;
  assign wb_rdata      = rdata_q;
  assign wb_rd         = rd_q;
  assign wb_err        = err_q;

endmodule

// File: doc/lsu_ctrl.md
# lsu_ctrl

Load/store unit sitting between the execute stage and the data-memory port. It accepts one memory operation at a time from execute and builds a word-aligned bus request with byte strobes and lane-replicated store data. It waits for the memory response under a timeout, then sign- or zero-extends load data and hands the result to write-back. All accesses are single-outstanding, and every operation is closed by exactly one write-back beat.

## Interface
- MAX_WAIT, 255: cycles allowed in REQ+WAIT before bus-timeout error; 1..255.
- clk  in  1  system clock, all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- ex_valid  in  1  execute presents an operation.
- ex_ready  out  1  LSU can accept; high only in IDLE.
- ex_is_load / ex_is_store  in  1 each  operation kind; never both high.
- ex_funct3  in  3  RV32 width code: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- ex_addr  in  32  effective byte address.
- ex_wdata  in  32  store data, right-justified.
- ex_rd  in  5  destination register, carried to write-back.
- mem_req_valid  out  1  request on bus.
- mem_req_ready  in  1  memory accepts request.
- mem_wen  out  1  1 = write.
- mem_addr  out  32  {addr[31:2],2'b00}.
- mem_wstrb  out  4  byte lanes written; 0000 for loads.
- mem_wdata  out  32  lane-replicated store data.
- mem_rsp_valid  in  1  response or write acknowledge.
- mem_rsp_rdata  in  32  full aligned read word.
- wb_valid  out  1  result available.
- wb_ready  in  1  write-back accepts.
- wb_rdata  out  32  extended load data; 0 for stores and errors.
- wb_rd  out  5  captured ex_rd.
- wb_err  out  1  misaligned, illegal funct3, or timeout.

## Operation
- States: IDLE, REQ, WAIT, DONE.
- **IDLE**
  - ex_ready=1.
  - On ex_valid: capture addr, funct3, wdata, rd, and kind.
  - Misaligned access, or illegal funct3, goes to DONE with err=1 and makes no bus access.
    - Misaligned: H/HU with addr[0]=1; W with addr[1:0]≠0.
    - Illegal funct3: store funct3 ∉ {000,001,010}; load funct3 ∉ {000,001,010,100,101}.
  - Neither load nor store goes to DONE with err=0 and rdata=0.
  - Otherwise go to REQ and clear the timeout counter.
- **REQ**
  - mem_req_valid=1, and all mem_* outputs are held stable.
  - mem_req_ready goes to WAIT.
  - mem_rsp_valid is ignored in REQ.
- **WAIT**
  - mem_rsp_valid goes to DONE.
  - For loads, extracted data is latched into wb_rdata.
  - For stores, the response is the write acknowledge.
- **Timeout**
  - The counter increments every cycle in REQ and WAIT.
  - When counter==MAX_WAIT-1 and no handshake occurs in that cycle, go to DONE with err=1.
  - A handshake in that same cycle takes priority over the timeout.
- **DONE**
  - wb_valid=1, and wb_* outputs are held.
  - wb_ready goes to IDLE.
- **Store encoding**
  - SB: wstrb=0001<<addr[1:0], wdata={4{wdata[7:0]}}.
  - SH: wstrb=0011<<{addr[1],1'b0}, wdata={2{wdata[15:0]}}.
  - SW: wstrb=1111, wdata passed through.
- **Load extraction**
  - Select byte mem_rsp_rdata[8*addr[1:0]+:8], or half mem_rsp_rdata[16*addr[1]+:16].
  - B/H sign-extend; BU/HU zero-extend; W passes through.
- **Reset**
  - Reset mid-operation aborts immediately to IDLE.
  - No write-back beat is produced for the aborted operation, and the request is dropped.

## Timing
- Reset values: state IDLE, ex_ready=1, mem_req_valid=0, mem_wen=0, mem_addr=0, mem_wstrb=0, mem_wdata=0, wb_valid=0, wb_rdata=0, wb_rd=0, wb_err=0.
- All outputs are Moore outputs: registered, or decoded from state only. There is no combinational path from any input to any output.
- Zero-wait memory:
  - Accept in cycle 0; mem_req_valid in cycle 1.
  - Response sampled in cycle 2; wb_valid in cycle 3.
  - Minimum latency is 3 cycles.
- Error shortcut (misaligned, illegal, non-memory): wb_valid in cycle 1.
- Back-to-back operations: a new accept is possible in the cycle after the wb handshake, giving a throughput of one operation per 4 cycles minimum.

## Structure
- Package lsu_pkg holds:
  - state enum;
  - funct3 constants (F3_B, F3_H, F3_W, F3_BU, F3_HU);
  - default MAX_WAIT.
- Sub-module lsu_load_align is purely combinational: inputs rdata, addr[1:0], funct3; output is the extended 32-bit value.
- The top block holds the FSM, capture registers, store encoder, and timeout counter.

## Test plan
- **LB:** addr 0x8000_0003, rsp rdata 0x80FF_1234 → mem_addr 0x8000_0000, wstrb 0000, wb_rdata 0xFFFF_FF80, wb_valid in cycle 3.
- **SH:** addr 0x8000_0002, wdata 0x0000_ABCD → wstrb 1100, mem_wdata 0xABCD_ABCD, mem_wen=1; after ack, wb_rdata=0, wb_err=0.
- **LW misaligned:** addr 0x8000_0001 → no mem_req_valid ever; wb_valid in cycle 1 with wb_err=1.
- **Timeout:** MAX_WAIT=4, mem_req_ready held 0 → err=1 in DONE after 4 REQ cycles; mem_req_valid drops.
- **Back-pressure:** LHU with rsp rdata 0xBEEF_0000, addr[1]=1, mem_req_ready delayed 2 cycles, wb_ready delayed 3 cycles → wb_rdata 0x0000_BEEF held stable and ex_ready=0 throughout.
- **Reset in WAIT:** rst asserted → all outputs return to reset values asynchronously; no wb_valid follows; the next operation completes normally.
